bnn_class_scorer: RTL and testbench
===================================

Name: bnn_class_scorer

Overview:
- Output-layer producer for the VAD classifier.
- Accumulates XNOR-popcount scores for the two output classes (0 = non-speech, 1 = speech) over one frame of binarized activations.
- Presents both scores and a 2-bit comparison vector with a valid/ready handshake.
- Feeds the downstream decision compare stage, which consumes the comparison vector.

Parameters:
- IN_W, 16: activation/weight bits delivered per beat.
- NUM_CHUNKS, 25: beats per frame; frame length is IN_W*NUM_CHUNKS bits.
- SCORE_W, derived localparam (not overridable): $clog2(IN_W*NUM_CHUNKS+1), extended when the optional feature is enabled.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame-start pulse.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid and in_ready are both high.
- act  input  IN_W  binarized activations for this beat.
- w0  input  IN_W  class-0 weights for this beat.
- w1  input  IN_W  class-1 weights for this beat.
- out_valid  output  1  scores available.
- out_ready  input  1  consumer takes the scores.
- score0  output  SCORE_W  class-0 score.
- score1  output  SCORE_W  class-1 score.
- cmp_out  output  2  bit1 = score1>score0, bit0 = score0>score1; tie gives 2'b00.

Behaviour:
- Reset: clk and rst, with rst asynchronous and active-high. While rst is high: state = IDLE, in_ready = 0, out_valid = 0, score0 = score1 = 0, cmp_out = 2'b00, beat counter = 0.
- Per accepted beat: acc0 += popcount(~(act ^ w0)) and acc1 += popcount(~(act ^ w1)). Arithmetic is unsigned and sized so it cannot overflow.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready = 0.
  - When start = 1: go to ACCUM, clear acc0, acc1 and the counter.
- ACCUM:
  - in_ready = 1 (registered; high from the cycle after start).
  - Each accepted beat increments the counter.
  - When the beat with counter = NUM_CHUNKS-1 is accepted: go to HOLD. On the same edge, load score0/score1 from the final sums (including that beat) and compute cmp_out.
  - out_valid rises in the cycle after the last beat is accepted (latency 1).
  - in_valid = 0 stalls accumulation; there is no timeout.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - score0, score1 and cmp_out stay stable until the transfer.
  - When out_ready = 1: out_valid drops on the next edge and the FSM returns to IDLE.
- Simultaneous events:
  - start during ACCUM aborts the frame: clear accumulators and counter, stay in ACCUM. A beat presented in the same cycle is discarded.
  - start in HOLD without out_ready is ignored.
  - start in HOLD with out_ready completes the transfer and goes directly to ACCUM, cleared.
- Reset mid-frame discards all partial sums and pending output.
- Boundary case: all-ones or all-zeros act against matching weights gives the maximum score, IN_W*NUM_CHUNKS.
- Boundary case: NUM_CHUNKS = 1 must work; the first accepted beat is also the last.

Optional Feature:
- Macro: BNN_SCORE_BIAS_EN.
- Defined:
  - Adds unsigned parameters BIAS0 and BIAS1 (default 0).
  - Accumulators initialise to BIAS0/BIAS1 instead of 0 on every clear.
  - SCORE_W = $clog2(IN_W*NUM_CHUNKS + max(BIAS0,BIAS1) + 1).
  - Reset values of score0/score1 remain 0.
- Undefined: no bias parameters, accumulators clear to 0, SCORE_W as above.

Decomposition:
- Package bnn_pkg holds:
  - state enum (IDLE/ACCUM/HOLD);
  - cmp_out encodings (CMP_SPEECH = 2'b10, CMP_NONSPEECH = 2'b01, CMP_TIE = 2'b00);
  - score-width helper function.
- Sub-module: xnor_popcount, a combinational popcount of ~(a^b) parameterised by IN_W. It is instantiated twice, once per class.

Test Plan:
- Reset mid-frame: assert rst after 10 of 25 beats, release, start a fresh frame -> first result reflects only the new frame; no out_valid from the aborted frame.
- Full match: IN_W=16, NUM_CHUNKS=25, act = w1 = 16'hFFFF, w0 = 16'h0000 for all beats -> score1 = 400, score0 = 0, cmp_out = 2'b10, out_valid one cycle after beat 25.
- Half match with stalls: act = 16'hFFFF, w0 = 16'h00FF, w1 = 16'h0F0F, in_valid toggled every other cycle -> score0 = score1 = 200, cmp_out = 2'b00; beat count unaffected by the gaps.
- Backpressure: hold out_ready = 0 for 7 cycles after out_valid, then pulse start -> outputs stable and start ignored throughout; pulse start together with out_ready -> FSM goes to ACCUM and in_ready rises next cycle.
- Abort: start asserted at beat 12 with in_valid = 1 -> that beat is discarded; the following 25 beats of act = w0 = 16'hAAAA, w1 = 16'h5555 give score0 = 400, score1 = 0, cmp_out = 2'b01.
- BNN_SCORE_BIAS_EN with BIAS1 = 3: otherwise tied frame (200/200) -> score1 = 203, cmp_out = 2'b10.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the VAD output-layer class scorer.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] CMP_SPEECH    = 2'b10;
  localparam logic [1:0] CMP_NONSPEECH = 2'b01;
  localparam logic [1:0] CMP_TIE       = 2'b00;

  // Bits needed to hold any score in 0..max_score.
  function automatic int score_width(input int max_score);
    return $clog2(max_score + 1);
  endfunction

endpackage

// File: rtl/bnn_class_scorer_xnor_popcount.sv
// Combinational XNOR-popcount: number of positions where a and b agree.
module xnor_popcount #(
  parameter  int IN_W  = 16,
  localparam int CNT_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [CNT_W-1:0] count
);

  logic [IN_W-1:0] match;

  assign match = ~(a ^ b);

  always_comb begin
    count = '0;
    for (int i = 0; i < IN_W; i++) begin
      count = count + CNT_W'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_class_scorer.sv
// Two-class XNOR-popcount score accumulator with valid/ready in and out.
// Optional per-class bias on accumulator clear: define BNN_SCORE_BIAS_EN.
module bnn_class_scorer
  import bnn_pkg::*;
#(
  parameter  int IN_W       = 16,
  parameter  int NUM_CHUNKS = 25,
`ifdef BNN_SCORE_BIAS_EN
  parameter  int unsigned BIAS0 = 0,
  parameter  int unsigned BIAS1 = 0,
  localparam int SCORE_W = score_width(IN_W*NUM_CHUNKS + int'((BIAS0 > BIAS1) ? BIAS0 : BIAS1))
`else
  localparam int SCORE_W = score_width(IN_W*NUM_CHUNKS)
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    act,
  input  logic [IN_W-1:0]    w0,
  input  logic [IN_W-1:0]    w1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [1:0]         cmp_out
);

  localparam int CNT_W   = $clog2(IN_W + 1);
  localparam int CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST = CHUNK_W'(NUM_CHUNKS - 1);
`ifdef BNN_SCORE_BIAS_EN
  localparam logic [SCORE_W-1:0] INIT0 = SCORE_W'(BIAS0);
  localparam logic [SCORE_W-1:0] INIT1 = SCORE_W'(BIAS1);
`else
  localparam logic [SCORE_W-1:0] INIT0 = '0;
  localparam logic [SCORE_W-1:0] INIT1 = '0;
`endif

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] acc0, acc1, sum0, sum1;
  logic [CNT_W-1:0]   pc0, pc1;
  logic [CHUNK_W-1:0] beat_cnt;
  logic               clear, take, last;

  xnor_popcount #(.IN_W(IN_W)) u_pc0 (.a(act), .b(w0), .count(pc0));
  xnor_popcount #(.IN_W(IN_W)) u_pc1 (.a(act), .b(w1), .count(pc1));

  assign sum0 = acc0 + SCORE_W'(pc0);
  assign sum1 = acc1 + SCORE_W'(pc1);
  assign last = take && (beat_cnt == LAST);

  // A start in ACCUM wins over a coincident beat, which is dropped.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          clear     = 1'b1;
        end
      end
      ACCUM: begin
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          take = 1'b1;
          if (beat_cnt == LAST) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            clear     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc0      <= '0;
      acc1      <= '0;
      beat_cnt  <= '0;
      score0    <= '0;
      score1    <= '0;
      cmp_out   <= CMP_TIE;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == HOLD);
      if (clear) begin
        acc0     <= INIT0;
        acc1     <= INIT1;
        beat_cnt <= '0;
      end else if (take) begin
        acc0     <= sum0;
        acc1     <= sum1;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (last) begin
        score0  <= sum0;
        score1  <= sum1;
        cmp_out <= (sum1 > sum0) ? CMP_SPEECH :
                   (sum0 > sum1) ? CMP_NONSPEECH : CMP_TIE;
      end
    end
  end

endmodule

// File: tb/tb_bnn_class_scorer.sv
// Scoreboard bench for bnn_class_scorer; honours BNN_SCORE_BIAS_EN (BIAS1 = 3).
module tb_bnn_class_scorer;

  localparam int IN_W = 16;
  localparam int NUM_CHUNKS = 25;
`ifdef BNN_SCORE_BIAS_EN
  localparam int B0 = 0;
  localparam int B1 = 3;
  localparam int SW = $clog2(IN_W*NUM_CHUNKS + 3 + 1);
`else
  localparam int B0 = 0;
  localparam int B1 = 0;
  localparam int SW = $clog2(IN_W*NUM_CHUNKS + 1);
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [IN_W-1:0] act = '0, w0 = '0, w1 = '0;
  logic [SW-1:0] score0, score1;
  logic [1:0] cmp_out;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [1:0]  c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m0, m1;

  always #5 clk = ~clk;

`ifdef BNN_SCORE_BIAS_EN
  bnn_class_scorer #(.IN_W(IN_W), .NUM_CHUNKS(NUM_CHUNKS), .BIAS0(0), .BIAS1(3)) dut (
`else
  bnn_class_scorer #(.IN_W(IN_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
`endif
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .w0(w0), .w1(w1), .out_valid(out_valid), .out_ready(out_ready),
    .score0(score0), .score1(score1), .cmp_out(cmp_out));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_cmp(input int s0, input int s1);
    return (s1 > s0) ? 2'b10 : (s0 > s1) ? 2'b01 : 2'b00;
  endfunction

  // Output side: every transfer pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("score0", 32'(score0), e.s0);
        check("score1", 32'(score1), e.s1);
        check("cmp_out", 32'(cmp_out), 32'(e.c));
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send_beat(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b0,
                           input logic [IN_W-1:0] b1);
    int n;
    act = a; w0 = b0; w1 = b1; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    m0 += $countones(~(a ^ b0));
    m1 += $countones(~(a ^ b1));
  endtask

  task automatic run_frame(input bit do_start, input int n, input logic [IN_W-1:0] a,
                           input logic [IN_W-1:0] b0, input logic [IN_W-1:0] b1,
                           input bit rnd, input int gap, input bit push);
    logic [IN_W-1:0] ta, tb0, tb1;
    m0 = B0; m1 = B1;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      ta = rnd ? IN_W'($urandom) : a;
      tb0 = rnd ? IN_W'($urandom) : b0;
      tb1 = rnd ? IN_W'($urandom) : b1;
      if (push && i == n-1) begin
        @(negedge clk);
        check("valid_before_last", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
      end
      send_beat(ta, tb0, tb1);
      for (int g = 0; g < gap && i < n-1; g++) begin
        @(posedge clk); #1;
      end
    end
    if (push) begin
      sb.push_back('{s0: 32'(m0), s1: 32'(m1), c: exp_cmp(m0, m1)});
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int e0, e1;
    #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_score0", 32'(score0), 32'd0);
    check("rst_score1", 32'(score1), 32'd0);
    check("rst_cmp", 32'(cmp_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame, then a fresh full-match frame.
    run_frame(1, 10, '0, '0, '0, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(1, NUM_CHUNKS, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 1);

    // All-zeros activations against matching class-0 weights.
    run_frame(1, NUM_CHUNKS, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 1);

    // Half match with a bubble between every beat.
    run_frame(1, NUM_CHUNKS, 16'hFFFF, 16'h00FF, 16'h0F0F, 0, 1, 1);

    // Backpressure on a random frame; start without out_ready is ignored.
    out_ready = 1'b0;
    run_frame(1, NUM_CHUNKS, '0, '0, '0, 1, 0, 1);
    e0 = m0; e1 = m1;
    for (int k = 0; k < 7; k++) begin
      start = (k == 3);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_score0", 32'(score0), 32'(e0));
      check("bp_score1", 32'(score1), 32'(e1));
      check("bp_cmp", 32'(cmp_out), 32'(exp_cmp(e0, e1)));
      @(posedge clk); #1;
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("hold_start_in_ready", 32'(in_ready), 32'd1);
    check("hold_start_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Abort at beat 12: the coincident beat is dropped.
    run_frame(0, 11, '0, '0, '0, 1, 0, 0);
    act = 16'hFFFF; w0 = 16'hFFFF; w1 = 16'hFFFF;
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    run_frame(0, NUM_CHUNKS, 16'hAAAA, 16'hAAAA, 16'h5555, 0, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
